// File: rtl/dev_uart_rx.sv
// 8N1 UART receiver with a first-word-fall-through input FIFO and sticky
// framing-error / overrun flags.
module dev_uart_rx #(
   parameter int CLK_FREQ   = 12_000_000,
   parameter int BAUD       = 9_600,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       getc_en,
   output logic [7:0] getc_char,
   input  logic       getc_pop,
   output logic       inbuf_full,
   output logic       frame_err,
   output logic       overrun,
   input  logic       clr_err
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam int PW  = $clog2(FIFO_DEPTH);
   // START is entered one clock after rxs falls, so the half-bit count ends two short.
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 2);
   localparam logic [CW-1:0] FULL_LAST = CW'(DIV - 1);
   localparam logic [PW:0]   DEPTH     = (PW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic          rx_p0, rx_p1, rxs;
   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    bit_cnt, bit_cnt_nxt;
   logic [7:0]    shift, shift_nxt;
   logic          push_nxt, fe_set;
   logic          push_p1;
   logic [7:0]    byte_p1;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0]   count;
   logic          do_push, do_pop;

   // stage p0/p1: two-flop synchroniser on the asynchronous rx pin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_p1 <= rx_p0;
      end
   end

   assign rxs = rx_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         push_p1 <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_cnt <= bit_cnt_nxt;
         push_p1 <= push_nxt;
      end
   end

   always_ff @(posedge clk) begin
      shift <= shift_nxt;
      if (push_nxt) byte_p1 <= shift;
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + 1'b1;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift;
      push_nxt    = 1'b0;
      fe_set      = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (!rxs) state_nxt = S_START;
         end
         S_START: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt     = '0;
               bit_cnt_nxt = '0;
               state_nxt   = rxs ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt == FULL_LAST) begin
               cnt_nxt     = '0;
               shift_nxt   = {rxs, shift[7:1]};
               bit_cnt_nxt = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt == FULL_LAST) begin
               cnt_nxt = '0;
               if (rxs) begin
                  push_nxt  = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  fe_set    = 1'b1;
                  state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            cnt_nxt = '0;
            if (rxs) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // stage p2: FIFO update from the registered push
   assign do_pop  = getc_pop && (count != '0);
   assign do_push = push_p1 && ((count != DEPTH) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
         frame_err <= (frame_err & ~clr_err) | fe_set;
         overrun   <= (overrun & ~clr_err) | (push_p1 & ~do_push);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= byte_p1;
   end

   assign getc_en    = (count != '0);
   assign inbuf_full = (count == DEPTH);
   assign getc_char  = getc_en ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_dev_uart_rx.sv
// Directed bench for dev_uart_rx at DIV=16, FIFO_DEPTH=8.
module tb_dev_uart_rx;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic       getc_en;
   logic [7:0] getc_char;
   logic       getc_pop;
   logic       inbuf_full;
   logic       frame_err;
   logic       overrun;
   logic       clr_err;

   int checks = 0;
   int errors = 0;

   dev_uart_rx #(
      .CLK_FREQ  (160),
      .BAUD      (10),
      .FIFO_DEPTH(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .getc_en   (getc_en),
      .getc_char (getc_char),
      .getc_pop  (getc_pop),
      .inbuf_full(inbuf_full),
      .frame_err (frame_err),
      .overrun   (overrun),
      .clr_err   (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; bit k of the frame is driven for 16 clocks starting at edge 16k+1.
   task automatic send_byte(input logic [7:0] b, input logic stop, input logic pop155,
                            input int cycles, output logic en154, output logic en155);
      logic [9:0] frame;
      frame = {stop, b, 1'b0};
      en154 = 1'b0;
      en155 = 1'b0;
      rx = frame[0];
      for (int e = 1; e <= cycles; e++) begin
         @(negedge clk);
         if (e == 154) begin
            en154 = getc_en;
            if (pop155) getc_pop = 1'b1;
         end
         if (e == 155) begin
            en155 = getc_en;
            getc_pop = 1'b0;
         end
         if (e % 16 == 0) rx = (e / 16 <= 9) ? frame[e / 16] : 1'b1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      idle(3);
      checks++; if (getc_en !== 1'b0) begin errors++; $display("FAIL reset_getc_en got %b want 0", getc_en); end
      checks++; if (getc_char !== 8'h00) begin errors++; $display("FAIL reset_getc_char got %h want 00", getc_char); end
      checks++; if (inbuf_full !== 1'b0) begin errors++; $display("FAIL reset_inbuf_full got %b want 0", inbuf_full); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
      rst_n = 1'b1;
      idle(4);
   endtask

   task automatic test_single;
      logic a, b;
      send_byte(8'hA5, 1'b1, 1'b0, 160, a, b);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL latency_early got %b want 0", a); end
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL latency_edge got %b want 1", b); end
      checks++; if (getc_char !== 8'hA5) begin errors++; $display("FAIL single_char got %h want a5", getc_char); end
      checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL single_flags got %b want 00", {frame_err, overrun}); end
      getc_pop = 1'b1;
      @(negedge clk);
      getc_pop = 1'b0;
      checks++; if (getc_en !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", getc_en); end
   endtask

   task automatic test_fill_overrun;
      logic a, b;
      for (int i = 1; i <= 9; i++) begin
         send_byte(8'(i), 1'b1, 1'b0, 160, a, b);
         if (i == 7) begin
            checks++; if (inbuf_full !== 1'b0) begin errors++; $display("FAIL full_early got %b want 0", inbuf_full); end
         end
         if (i == 8) begin
            checks++; if (inbuf_full !== 1'b1) begin errors++; $display("FAIL full_at8 got %b want 1", inbuf_full); end
            checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_at8 got %b want 0", overrun); end
         end
      end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_at9 got %b want 1", overrun); end
      for (int i = 1; i <= 8; i++) begin
         checks++; if (getc_char !== 8'(i)) begin errors++; $display("FAIL fill_order%0d got %h want %h", i, getc_char, 8'(i)); end
         getc_pop = 1'b1;
         @(negedge clk);
         getc_pop = 1'b0;
      end
      checks++; if (getc_en !== 1'b0) begin errors++; $display("FAIL fill_drained got %b want 0", getc_en); end
      getc_pop = 1'b1;
      @(negedge clk);
      getc_pop = 1'b0;
      checks++; if ({getc_en, inbuf_full} !== 2'b00) begin errors++; $display("FAIL pop_empty got %b want 00", {getc_en, inbuf_full}); end
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b want 0", overrun); end
   endtask

   task automatic test_glitch;
      logic a, b;
      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(40);
      checks++; if ({getc_en, frame_err} !== 2'b00) begin errors++; $display("FAIL glitch got %b want 00", {getc_en, frame_err}); end
      send_byte(8'h3C, 1'b1, 1'b0, 160, a, b);
      checks++; if (getc_char !== 8'h3C) begin errors++; $display("FAIL glitch_next got %h want 3c", getc_char); end
      getc_pop = 1'b1;
      @(negedge clk);
      getc_pop = 1'b0;
      checks++; if (getc_en !== 1'b0) begin errors++; $display("FAIL glitch_drain got %b want 0", getc_en); end
   endtask

   task automatic test_frame_err;
      logic a, b;
      send_byte(8'h55, 1'b0, 1'b0, 158, a, b);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_err_set got %b want 1", frame_err); end
      checks++; if (getc_en !== 1'b0) begin errors++; $display("FAIL frame_err_drop got %b want 0", getc_en); end
      rx = 1'b0;
      idle(20 * 16);
      rx = 1'b1;
      idle(32);
      checks++; if (getc_en !== 1'b0) begin errors++; $display("FAIL break_reject got %b want 0", getc_en); end
      send_byte(8'h7E, 1'b1, 1'b0, 160, a, b);
      checks++; if (getc_char !== 8'h7E) begin errors++; $display("FAIL after_break got %h want 7e", getc_char); end
      getc_pop = 1'b1;
      @(negedge clk);
      getc_pop = 1'b0;
      checks++; if (getc_en !== 1'b0) begin errors++; $display("FAIL after_break_alone got %b want 0", getc_en); end
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_err_sticky got %b want 1", frame_err); end
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_err_clear got %b want 0", frame_err); end
   endtask

   task automatic test_full_pop;
      logic a, b;
      for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1, 1'b0, 160, a, b);
      send_byte(8'h99, 1'b1, 1'b1, 160, a, b);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fullpop_overrun got %b want 0", overrun); end
      checks++; if (inbuf_full !== 1'b1) begin errors++; $display("FAIL fullpop_count got %b want 1", inbuf_full); end
      for (int i = 1; i <= 8; i++) begin
         if (i < 8) begin
            checks++; if (getc_char !== 8'h10 + 8'(i)) begin errors++; $display("FAIL fullpop_order%0d got %h want %h", i, getc_char, 8'h10 + 8'(i)); end
         end else begin
            checks++; if (getc_char !== 8'h99) begin errors++; $display("FAIL fullpop_last got %h want 99", getc_char); end
         end
         getc_pop = 1'b1;
         @(negedge clk);
         getc_pop = 1'b0;
      end
      checks++; if (getc_en !== 1'b0) begin errors++; $display("FAIL fullpop_drained got %b want 0", getc_en); end
   endtask

   task automatic test_reset_mid;
      logic a, b;
      send_byte(8'h21, 1'b1, 1'b0, 160, a, b);
      send_byte(8'h22, 1'b1, 1'b0, 160, a, b);
      checks++; if (getc_en !== 1'b1) begin errors++; $display("FAIL midrst_queued got %b want 1", getc_en); end
      send_byte(8'h42, 1'b1, 1'b0, 60, a, b);
      rst_n = 1'b0;
      #1;
      checks++; if (getc_en !== 1'b0) begin errors++; $display("FAIL midrst_async got %b want 0", getc_en); end
      rx = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(20);
      send_byte(8'h17, 1'b1, 1'b0, 160, a, b);
      checks++; if (getc_char !== 8'h17) begin errors++; $display("FAIL midrst_next got %h want 17", getc_char); end
      getc_pop = 1'b1;
      @(negedge clk);
      getc_pop = 1'b0;
      checks++; if (getc_en !== 1'b0) begin errors++; $display("FAIL midrst_alone got %b want 0", getc_en); end
   endtask

   initial begin
      rst_n    = 1'b0;
      rx       = 1'b1;
      getc_pop = 1'b0;
      clr_err  = 1'b0;
      @(negedge clk);
      test_reset;
      test_single;
      test_fill_overrun;
      test_glitch;
      test_frame_err;
      test_full_pop;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
